// File: rtl/tcdm_responder.sv
// rtl/tcdm_responder.sv - TCDM memory target with fixed-latency response pipeline and credit-limited response FIFO
module tcdm_responder #(
    parameter int DataWidth      = 32,
    parameter int AddrWidth      = 32,
    parameter int IdWidth        = 10,
    parameter int NumWords       = 256,
    parameter int Latency        = 2,
    parameter int MaxOutstanding = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            tcdm_req_valid_i,
    output logic                            tcdm_req_ready_o,
    input  logic [AddrWidth-1:0]            tcdm_req_tgt_addr_i,
    input  logic                            tcdm_req_wen_i,
    input  logic [DataWidth-1:0]            tcdm_req_wdata_i,
    input  logic [DataWidth/8-1:0]          tcdm_req_be_i,
    input  logic [IdWidth-1:0]              tcdm_req_id_i,
    output logic                            tcdm_resp_valid_o,
    input  logic                            tcdm_resp_ready_i,
    output logic [DataWidth-1:0]            tcdm_resp_rdata_o,
    output logic [IdWidth-1:0]              tcdm_resp_id_o,
    output logic [$clog2(MaxOutstanding):0] outstanding_o
);

    localparam int BeWidth  = DataWidth / 8;
    localparam int OffWidth = $clog2(BeWidth);
    localparam int WordAw   = $clog2(NumWords);
    localparam int CntWidth = $clog2(MaxOutstanding) + 1;
    localparam int PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    // Storage, deliberately without reset so contents survive a mid-run reset
    logic [DataWidth-1:0] r_mem [NumWords];

    // Fixed-latency pipeline carrying the captured read word and ID
    logic [Latency-1:0]   r_pipe_valid;
    logic [DataWidth-1:0] r_pipe_data [Latency];
    logic [IdWidth-1:0]   r_pipe_id   [Latency];

    // Response FIFO sized to the credit limit, so it can never overflow
    logic [DataWidth-1:0] r_fifo_data [MaxOutstanding];
    logic [IdWidth-1:0]   r_fifo_id   [MaxOutstanding];
    logic [PtrWidth-1:0]  r_wptr;
    logic [PtrWidth-1:0]  r_rptr;
    logic [CntWidth-1:0]  r_fifo_cnt;

    // Credits: accepted requests whose response has not yet been handshaken
    logic [CntWidth-1:0]  r_outstanding;

    logic                 w_accept;
    logic [WordAw-1:0]    w_word_idx;
    logic                 w_tail_valid;
    logic [DataWidth-1:0] w_tail_data;
    logic [IdWidth-1:0]   w_tail_id;
    logic                 w_fifo_empty;
    logic                 w_bypass;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_resp_hs;
    logic                 w_unused_addr;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        if (p == PtrWidth'(MaxOutstanding - 1)) begin
            return '0;
        end
        return p + PtrWidth'(1);
    endfunction

    // Ready depends only on the registered credit count, never on valid or resp_ready
    assign tcdm_req_ready_o = (r_outstanding < CntWidth'(MaxOutstanding));
    assign outstanding_o    = r_outstanding;

    // Requests arriving during reset are neither accepted nor written
    assign w_accept   = tcdm_req_valid_i && tcdm_req_ready_o && !rst_i;
    assign w_word_idx = tcdm_req_tgt_addr_i[OffWidth +: WordAw];

    // Upper and byte-offset address bits do not select anything
    assign w_unused_addr = ^tcdm_req_tgt_addr_i;

    assign w_tail_valid = r_pipe_valid[Latency-1];
    assign w_tail_data  = r_pipe_data[Latency-1];
    assign w_tail_id    = r_pipe_id[Latency-1];

    // An empty FIFO lets the pipeline tail fall straight through to the response port;
    // if the consumer stalls, the tail still moves into the FIFO and is re-presented from there
    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_bypass     = w_fifo_empty && tcdm_resp_ready_i;
    assign w_push       = w_tail_valid && !w_bypass;
    assign w_pop        = !w_fifo_empty && tcdm_resp_ready_i;

    assign tcdm_resp_valid_o = w_fifo_empty ? w_tail_valid : 1'b1;
    assign tcdm_resp_rdata_o = w_fifo_empty ? w_tail_data  : r_fifo_data[r_rptr];
    assign tcdm_resp_id_o    = w_fifo_empty ? w_tail_id    : r_fifo_id[r_rptr];
    assign w_resp_hs         = tcdm_resp_valid_o && tcdm_resp_ready_i;

    // Byte-enabled write on acceptance; the read side sees the old word on the same edge
    always_ff @(posedge clk_i) begin
        if (w_accept && tcdm_req_wen_i) begin
            for (int b = 0; b < BeWidth; b++) begin
                if (tcdm_req_be_i[b]) begin
                    r_mem[w_word_idx][b*8 +: 8] <= tcdm_req_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Capture the pre-write word and ID, then shift them down the pipeline every cycle
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_pipe_data[0] <= r_mem[w_word_idx];
            r_pipe_id[0]   <= tcdm_req_id_i;
        end
        for (int k = 1; k < Latency; k++) begin
            r_pipe_data[k] <= r_pipe_data[k-1];
            r_pipe_id[k]   <= r_pipe_id[k-1];
        end
    end

    // Pipeline valid bits never stall; reset drops everything in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pipe_valid <= '0;
        end else begin
            r_pipe_valid[0] <= w_accept;
            for (int k = 1; k < Latency; k++) begin
                r_pipe_valid[k] <= r_pipe_valid[k-1];
            end
        end
    end

    // FIFO storage write for tail entries that could not bypass
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= w_tail_data;
            r_fifo_id[r_wptr]   <= w_tail_id;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CntWidth'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CntWidth'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Credit counter: up on accept, down on response handshake, unchanged when both
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_outstanding <= '0;
        end else begin
            case ({w_accept, w_resp_hs})
                2'b10:   r_outstanding <= r_outstanding + CntWidth'(1);
                2'b01:   r_outstanding <= r_outstanding - CntWidth'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

endmodule

// File: doc/tcdm_responder.md
TCDM_RESPONDER -- requirements
Module: tcdm_responder

Interface
REQ-001 SHALL have parameter DataWidth, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter AddrWidth, default 32, meaning byte-address width.
REQ-003 SHALL have parameter IdWidth, default 10, meaning transaction ID width.
REQ-004 SHALL have parameter NumWords, default 256, meaning memory depth in words (power of two).
REQ-005 SHALL have parameter Latency, default 2, meaning accept-to-response cycles (legal range 1..8).
REQ-006 SHALL have parameter MaxOutstanding, default 4, meaning maximum accepted-but-unreturned requests (power of two, ≥1).
REQ-007 SHALL have port clk_i, input, 1 bit: the single clock; one clock, all state on rising edge.
REQ-008 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port tcdm_req_valid_i, input, 1 bit: request valid.
REQ-010 SHALL have port tcdm_req_ready_o, output, 1 bit: request accepted when valid&ready.
REQ-011 SHALL have port tcdm_req_tgt_addr_i, input, AddrWidth: byte address.
REQ-012 SHALL have port tcdm_req_wen_i, input, 1 bit: 1=write, 0=read.
REQ-013 SHALL have port tcdm_req_wdata_i, input, DataWidth: write data.
REQ-014 SHALL have port tcdm_req_be_i, input, DataWidth/8: byte enables.
REQ-015 SHALL have port tcdm_req_id_i, input, IdWidth: transaction ID.
REQ-016 SHALL have port tcdm_resp_valid_o, output, 1 bit: response valid.
REQ-017 SHALL have port tcdm_resp_ready_i, input, 1 bit: response consumed when valid&ready.
REQ-018 SHALL have port tcdm_resp_rdata_o, output, DataWidth: response data.
REQ-019 SHALL have port tcdm_resp_id_o, input-echoed ID, output, IdWidth.
REQ-020 SHALL have port outstanding_o, output, $clog2(MaxOutstanding)+1: count of in-flight plus queued responses.

Function
REQ-021 SHALL index memory by word = addr[$clog2(DataWidth/8) +: $clog2(NumWords)]; upper and byte-offset bits ignored.
REQ-022 SHALL drive tcdm_req_ready_o = (outstanding_o < MaxOutstanding), with no combinational path from tcdm_resp_ready_i or tcdm_req_valid_i.
REQ-023 SHALL, on acceptance, sample the addressed word as rdata, then on the same edge write wdata to bytes with be=1 if wen=1 (read-before-write; write response carries pre-write word).
REQ-024 SHALL produce exactly one response per accepted request, carrying the accepted ID, in acceptance order.
REQ-025 SHALL carry each accepted request through a Latency-stage valid/data/ID shift pipeline that never stalls, then into a response FIFO of depth MaxOutstanding.
REQ-026 SHALL, with FIFO empty and tcdm_resp_ready_i=1, assert tcdm_resp_valid_o exactly Latency cycles after the acceptance edge (FIFO fall-through, zero added latency).
REQ-027 SHALL hold tcdm_resp_valid_o, rdata and ID stable while valid&!ready.
REQ-028 SHALL increment outstanding_o on acceptance, decrement on response handshake, and leave it unchanged when both occur in one cycle.
REQ-029 SHALL never overflow the FIFO; the credit rule of REQ-022 guarantees space.
REQ-030 SHALL allow one acceptance per cycle sustained when tcdm_resp_ready_i=1 and MaxOutstanding ≥ Latency+1.
REQ-031 SHALL make a request accepted at cycle t observe all writes accepted at cycles < t.

Reset
REQ-032 SHALL, with rst_i=1 at a rising edge, clear pipeline valids, FIFO pointers and outstanding_o to 0; tcdm_resp_valid_o=0 and tcdm_req_ready_o=1 in the following cycle.
REQ-033 SHALL drop in-flight/queued responses on reset mid-operation; memory contents SHALL NOT be reset.
REQ-034 SHALL ignore tcdm_req_valid_i during reset cycles (no acceptance, no write).

Verification
REQ-035 Single read: write 0xDEADBEEF to addr 0x40 (be=0xF, ID 3), then read 0x40 ID 7 -> responses ID 3 then ID 7 rdata 0xDEADBEEF, each Latency=2 cycles after acceptance.
REQ-036 Byte enables: word 0x11223344 at addr 0x8, write 0xAABBCCDD be=0b0101 -> later read returns 0x11BB33DD.
REQ-037 Backpressure: resp_ready=0, valid=1 every cycle -> exactly 4 accepts, ready=0, outstanding_o=4; release ready -> 4 responses in order, IDs 0..3.
REQ-038 Simultaneous accept and return at outstanding_o=4-1=3: outstanding_o stays 3, ready stays 1.
REQ-039 Reset mid-burst: 3 requests in flight, rst_i pulsed 1 cycle -> no responses emitted, outstanding_o=0, earlier writes still readable.
REQ-040 Streaming: resp_ready=1, 100 back-to-back reads -> 100 accepts in 100 cycles, responses in order, IDs echoed.
